// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, 1 or 2 stop bits, one-entry holding register.
// Define UART_TX_PARITY_EN to insert a parity bit (even/odd per PARITY_ODD) after the data bits.
module uart_tx #(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);
    localparam int unsigned BIT_PERIOD = CLOCK_FREQ / BAUD_RATE;
    localparam logic [15:0] BIT_RELOAD = 16'(BIT_PERIOD - 1);
    localparam logic        STOP_INIT  = 1'(STOP_BITS - 1);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (BIT_PERIOD < 2 || BIT_PERIOD > 65536) begin : g_bad_bit_period
        $error("uart_tx: CLOCK_FREQ / BAUD_RATE must be in 2..65536");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_INV = 1'(PARITY_ODD);
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e      state_q;
    logic [7:0]  hold_q;
    logic        hold_valid_q;
    logic [7:0]  shift_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic        stop_idx_q;
    logic        tx_q;
    logic [2:0]  next_idx;

    assign next_idx = bit_idx_q + 3'd1;
    assign ready    = !hold_valid_q;
    assign busy     = (state_q != StIdle) || hold_valid_q;
    assign tx       = tx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            // Accept and drain never coincide: ready is low whenever hold is full.
            if (valid && ready) begin
                hold_q       <= data;
                hold_valid_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (hold_valid_q) begin
                        shift_q      <= hold_q;
                        hold_valid_q <= 1'b0;
                        tx_q         <= 1'b0;
                        cnt_q        <= BIT_RELOAD;
                        state_q      <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == 16'd0) begin
                        tx_q      <= shift_q[0];
                        bit_idx_q <= 3'd0;
                        cnt_q     <= BIT_RELOAD;
                        state_q   <= StData;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                StData: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q <= BIT_RELOAD;
                        if (bit_idx_q != 3'd7) begin
                            bit_idx_q <= next_idx;
                            tx_q      <= shift_q[next_idx];
                        end else begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= (^shift_q) ^ PARITY_INV;
                            state_q <= StParity;
`else
                            tx_q       <= 1'b1;
                            stop_idx_q <= STOP_INIT;
                            state_q    <= StStop;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (cnt_q == 16'd0) begin
                        tx_q       <= 1'b1;
                        cnt_q      <= BIT_RELOAD;
                        stop_idx_q <= STOP_INIT;
                        state_q    <= StStop;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
`endif
                StStop: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else if (stop_idx_q) begin
                        stop_idx_q <= 1'b0;
                        cnt_q      <= BIT_RELOAD;
                    end else if (hold_valid_q) begin
                        // Chain straight into the next start bit, no idle cycle.
                        shift_q      <= hold_q;
                        hold_valid_q <= 1'b0;
                        tx_q         <= 1'b0;
                        cnt_q        <= BIT_RELOAD;
                        state_q      <= StStart;
                    end else begin
                        tx_q    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: single frame, back-to-back, backpressure, reset abort,
// two stop bits, and parity bit values when UART_TX_PARITY_EN is defined.
module tb_uart_tx;
    localparam int BP = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME1 = (10 + PB) * BP;
    localparam int FRAME2 = (11 + PB) * BP;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;
    logic       par_seen;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .data(data_a), .valid(valid_a),
        .ready(ready_a), .tx(tx_a), .busy(busy_a)
    );

    uart_tx #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .data(data_b), .valid(valid_b),
        .ready(ready_b), .tx(tx_b), .busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level c cycles after the start bit began (even parity when enabled).
    function automatic logic exp_bit(input logic [7:0] b, input int c);
        if (c < BP) return 1'b0;
        if (c < 9 * BP) return b[(c - BP) / BP];
        if (PB != 0 && c < 10 * BP) return ^b;
        return 1'b1;
    endfunction

    function automatic logic cur_tx(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction

    function automatic logic cur_ready(input bit sel);
        return sel ? ready_b : ready_a;
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    task automatic drive(input bit sel, input logic [7:0] d, input logic v);
        if (sel) begin
            data_b  = d;
            valid_b = v;
        end else begin
            data_a  = d;
            valid_a = v;
        end
    endtask

    // One frame of b0, or b0 then b1 queued as soon as ready rises.
    task automatic run_frames(input bit sel, input logic [7:0] b0, input logic [7:0] b1,
                              input bit two, input int frame, input string tag);
        logic [7:0] b;
        int n;
        n = two ? 2 * frame : frame;
        @(negedge clk);
        check_eq({tag, "_ready_idle"}, cur_ready(sel), 1);
        drive(sel, b0, 1'b1);
        @(negedge clk);
        drive(sel, 8'hEE, 1'b0);
        check_eq({tag, "_ready_full"}, cur_ready(sel), 0);
        check_eq({tag, "_busy_accept"}, cur_busy(sel), 1);
        check_eq({tag, "_tx_before_start"}, cur_tx(sel), 1);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (two && c == 0) begin
                check_eq({tag, "_ready_drained"}, cur_ready(sel), 1);
                drive(sel, b1, 1'b1);
            end else if (two && c == 1) begin
                check_eq({tag, "_ready_second"}, cur_ready(sel), 0);
                drive(sel, 8'hEE, 1'b0);
            end
            if (c == 9 * BP + 5) par_seen = cur_tx(sel);
            b = (c < frame) ? b0 : b1;
            check_eq($sformatf("%s_tx_c%0d", tag, c), cur_tx(sel), exp_bit(b, c % frame));
        end
        check_eq({tag, "_busy_last_stop"}, cur_busy(sel), 1);
        @(negedge clk);
        check_eq({tag, "_busy_end"}, cur_busy(sel), 0);
        check_eq({tag, "_tx_idle"}, cur_tx(sel), 1);
        check_eq({tag, "_ready_end"}, cur_ready(sel), 1);
    endtask

    initial begin
        logic [7:0] b;
        logic       exp_r;
        rst_n   = 1'b0;
        data_a  = 8'h00;
        valid_a = 1'b0;
        data_b  = 8'h00;
        valid_b = 1'b0;
        par_seen = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_tx", tx_a, 1);
        check_eq("rst_ready", ready_a, 1);
        check_eq("rst_busy", busy_a, 0);
        rst_n = 1'b1;

        run_frames(1'b0, 8'hA5, 8'h00, 1'b0, FRAME1, "single_a5");
        run_frames(1'b0, 8'h55, 8'h0F, 1'b1, FRAME1, "b2b");

        // Backpressure: valid stays high, data changes every cycle.
        @(negedge clk);
        check_eq("bp_ready_idle", ready_a, 1);
        data_a  = 8'h11;
        valid_a = 1'b1;
        @(negedge clk);
        data_a = 8'hEE;
        for (int c = 0; c < 3 * FRAME1; c++) begin
            @(negedge clk);
            exp_r = (c == 0 || c == FRAME1 || c >= 2 * FRAME1);
            check_eq($sformatf("bp_ready_c%0d", c), ready_a, exp_r);
            if (c <= FRAME1) data_a = 8'(8'h30 + c);
            else valid_a = 1'b0;
            b = (c < FRAME1) ? 8'h11 : (c < 2 * FRAME1) ? 8'h30 : 8'(8'h30 + FRAME1);
            check_eq($sformatf("bp_tx_c%0d", c), tx_a, exp_bit(b, c % FRAME1));
        end
        check_eq("bp_busy_last", busy_a, 1);
        @(negedge clk);
        check_eq("bp_busy_end", busy_a, 0);

        // Reset during data bit 3, with a valid presented at the reset edge.
        @(negedge clk);
        data_a  = 8'hC3;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            check_eq($sformatf("abort_tx_c%0d", c), tx_a, exp_bit(8'hC3, c));
        end
        rst_n   = 1'b0;
        data_a  = 8'h99;
        valid_a = 1'b1;
        @(negedge clk);
        rst_n   = 1'b1;
        valid_a = 1'b0;
        check_eq("abort_tx", tx_a, 1);
        check_eq("abort_ready", ready_a, 1);
        check_eq("abort_busy", busy_a, 0);
        run_frames(1'b0, 8'h3C, 8'h00, 1'b0, FRAME1, "after_abort_3c");

        run_frames(1'b1, 8'hFF, 8'h00, 1'b1, FRAME2, "stop2");

`ifdef UART_TX_PARITY_EN
        run_frames(1'b0, 8'h07, 8'h00, 1'b0, FRAME1, "par_07");
        check_eq("parity_07", par_seen, 1);
        run_frames(1'b0, 8'h03, 8'h00, 1'b0, FRAME1, "par_03");
        check_eq("parity_03", par_seen, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
